// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_scanner
// Description : Multiplexed seven-segment display driver. Scans DIGIT_COUNT
//               hex digits at a programmable refresh rate. A loaded value is
//               held in a shadow register and committed only at a frame
//               boundary, so a frame never shows a mix of old and new digits.
//               Digits can be blanked individually with digit_enable.
//               Optional macro LEADING_ZERO_BLANK_EN also blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_scanner #(
    parameter int DIGIT_COUNT    = 4,
    parameter int REFRESH_DIVIDE = 100000,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         load,
    input  logic [4*DIGIT_COUNT-1:0]     value,
    input  logic [DIGIT_COUNT-1:0]       digit_enable,
    output logic [DIGIT_COUNT-1:0]       anode,
    output logic [6:0]                   segment,
    output logic [((DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1)-1:0] digit_index,
    output logic                         frame_done,
    output logic                         pending
);

    localparam int IDX_W = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;
    localparam int CNT_W = (REFRESH_DIVIDE > 1) ? $clog2(REFRESH_DIVIDE) : 1;
    localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(DIGIT_COUNT - 1);
    localparam logic [CNT_W-1:0]       LAST_CNT   = CNT_W'(REFRESH_DIVIDE - 1);
    // XOR masks that turn active-high internal levels into pin polarity;
    // they are also the "everything off" pin levels.
    localparam logic [DIGIT_COUNT-1:0] ANODE_POL  = ACTIVE_LOW ? '1 : '0;
    localparam logic [6:0]             SEG_POL    = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [CNT_W-1:0]           prescale;
    logic [4*DIGIT_COUNT-1:0]   shadow;
    logic [4*DIGIT_COUNT-1:0]   display;
    logic                       tick;
    logic                       wrap;
    logic [3:0]                 nibble;
    logic [6:0]                 hex_seg;
    logic [DIGIT_COUNT-1:0]     lz_blank;
    logic                       blank;
    logic [DIGIT_COUNT-1:0]     anode_on;

    assign tick = (prescale == LAST_CNT);
    assign wrap = tick && (digit_index == LAST_IDX);

    // Refresh prescaler: one tick every REFRESH_DIVIDE cycles
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            prescale <= '0;
        else if (tick)
            prescale <= '0;
        else
            prescale <= prescale + 1'b1;
    end

    // Digit scan index and frame boundary pulse, registered together
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digit_index <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (tick)
                digit_index <= (digit_index == LAST_IDX) ? '0 : digit_index + 1'b1;
        end
    end

    // Shadow capture and tear-free commit at the frame wrap; a load landing
    // on the wrap tick bypasses the shadow and never raises pending
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow  <= '0;
            display <= '0;
            pending <= 1'b0;
        end else begin
            if (load)
                shadow <= value;
            if (wrap && (pending || load)) begin
                display <= load ? value : shadow;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Leading-zero blank mask, derived from the committed display only
`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = DIGIT_COUNT - 1; i > 0; i--) begin
            zero_run    = zero_run & (display[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_run;
        end
    end
`else
    always_comb begin
        lz_blank = '0;
    end
`endif

    // Hex decode of the digit currently being scanned (active-high gfedcba)
    always_comb begin
        nibble   = display[{digit_index, 2'b00} +: 4];
        blank    = ~digit_enable[digit_index] | lz_blank[digit_index];
        anode_on = DIGIT_COUNT'(1) << digit_index;
        hex_seg  = 7'h00;
        case (nibble)
            4'h0: hex_seg = 7'h3F;
            4'h1: hex_seg = 7'h06;
            4'h2: hex_seg = 7'h5B;
            4'h3: hex_seg = 7'h4F;
            4'h4: hex_seg = 7'h66;
            4'h5: hex_seg = 7'h6D;
            4'h6: hex_seg = 7'h7D;
            4'h7: hex_seg = 7'h07;
            4'h8: hex_seg = 7'h7F;
            4'h9: hex_seg = 7'h6F;
            4'hA: hex_seg = 7'h77;
            4'hB: hex_seg = 7'h7C;
            4'hC: hex_seg = 7'h39;
            4'hD: hex_seg = 7'h5E;
            4'hE: hex_seg = 7'h79;
            default: hex_seg = 7'h71;
        endcase
    end

    // Registered pin drivers, one cycle behind the index/display state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            anode   <= ANODE_POL;
            segment <= SEG_POL;
        end else begin
            anode   <= (blank ? '0 : anode_on) ^ ANODE_POL;
            segment <= (blank ? 7'h00 : hex_seg) ^ SEG_POL;
        end
    end

endmodule
`default_nettype wire
